// File: rtl/mest_pro_imem_if.sv
// MEST Pro memory bus between processor core (master) and memory (slave).
// Ports: request/address/write data/control in, read data/valid/error/busy out.
interface mest_pro_imem_if #(
    parameter int AW = 16,
    parameter int W  = 28
);
    logic          i_req;
    logic [AW-1:0] i_prog_counter;
    logic [W-1:0]  i_data2store;
    logic          i_WE;
    logic          i_CS;
    logic          i_RESET;
    logic [W-1:0]  o_instruction;
    logic          o_instr_valid;
    logic          o_ERROR;
    logic          o_busy;

    modport master (
        output i_req,
        output i_prog_counter,
        output i_data2store,
        output i_WE,
        output i_CS,
        output i_RESET,
        input  o_instruction,
        input  o_instr_valid,
        input  o_ERROR,
        input  o_busy
    );

    modport slave (
        input  i_req,
        input  i_prog_counter,
        input  i_data2store,
        input  i_WE,
        input  i_CS,
        input  i_RESET,
        output o_instruction,
        output o_instr_valid,
        output o_ERROR,
        output o_busy
    );
endinterface

// File: rtl/mest_pro_imem.sv
// MEST Pro program/data memory responder with fixed read latency and clear engine.
// Ports: clk, i_reset_n (sync, active-low), bus (mest_pro_imem_if.slave).
module mest_pro_imem #(
    parameter int OP_CODE_SIZE     = 4,
    parameter int INSTRUCTION_SIZE = OP_CODE_SIZE + 24,
    parameter int ROM_DEPTH        = 65536,
    parameter int MEM_WORDS        = 256,
    parameter int READ_LATENCY     = 2
) (
    input logic            clk,
    input logic            i_reset_n,
    mest_pro_imem_if.slave bus
);
    localparam int W  = INSTRUCTION_SIZE;
    localparam int L  = READ_LATENCY;
    localparam int PW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic {CLEAR, READY} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] ptr_q;
    logic [W-1:0]  mem [MEM_WORDS];

    logic [L-1:0]  p_valid;
    logic [L-1:0]  p_rd;
    logic [L-1:0]  p_err;
    logic [W-1:0]  p_data [L];

    logic [W-1:0]  instr_q;
    logic          valid_q;
    logic          err_q;

    logic          in_range;
    logic [PW-1:0] idx;
    logic          accept;
    logic          busy_err;
    logic          flush;
    logic          last;
    logic          resp;

    assign in_range = 32'(bus.i_prog_counter) < 32'(MEM_WORDS);
    assign idx      = bus.i_prog_counter[PW-1:0];
    assign accept   = (state_q == READY) && bus.i_req && bus.i_CS && !bus.i_RESET;
    assign busy_err = (state_q == CLEAR) && bus.i_req && bus.i_CS;
    assign flush    = (state_q == READY) && bus.i_RESET;
    assign last     = ptr_q == PW'(MEM_WORDS - 1);
    // Final stage carries an entry that must surface on the outputs.
    assign resp     = p_valid[L-1] && !flush;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR: if (!bus.i_RESET && last) state_d = READY;
            READY: if (bus.i_RESET) state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            // Soft reset restarts the sweep from word 0.
            if (state_q == READY || bus.i_RESET) ptr_q <= '0;
            else ptr_q <= ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset_n) begin
            if (state_q == CLEAR) mem[ptr_q] <= '0;
            else if (accept && bus.i_WE && in_range) mem[idx] <= bus.i_data2store;
        end
    end

    // Only reads and out-of-range writes occupy a pipeline slot.
    always_ff @(posedge clk) begin
        if (!i_reset_n || flush) begin
            p_valid <= '0;
        end else begin
            p_valid[0] <= accept && (!bus.i_WE || !in_range);
            for (int i = 1; i < L; i++) p_valid[i] <= p_valid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        p_rd[0]   <= !bus.i_WE;
        p_err[0]  <= !in_range;
        p_data[0] <= (in_range && !bus.i_WE) ? mem[idx] : '0;
        for (int i = 1; i < L; i++) begin
            p_rd[i]   <= p_rd[i-1];
            p_err[i]  <= p_err[i-1];
            p_data[i] <= p_data[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= resp && p_rd[L-1];
            err_q   <= busy_err || (resp && p_err[L-1]);
            if (resp && p_rd[L-1]) instr_q <= p_data[L-1];
        end
    end

    assign bus.o_instruction = instr_q;
    assign bus.o_instr_valid = valid_q;
    assign bus.o_ERROR       = err_q;
    assign bus.o_busy        = (state_q == CLEAR);
endmodule

// File: tb/tb_mest_pro_imem.sv
// Scoreboard bench for mest_pro_imem: directed accesses, expected responses queued.
// Drives the master side of mest_pro_imem_if; monitor checks data, flags and timing.
module tb_mest_pro_imem;
    localparam int W   = 28;
    localparam int AW  = 16;
    localparam int LAT = 2;
    localparam int MW  = 256;

    typedef struct {
        logic [W-1:0] d;
        bit           v;
        bit           e;
        int           due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 0;
    exp_t sb[$];
    exp_t mx;
    int   n;

    mest_pro_imem_if #(.AW(AW), .W(W)) bus ();

    mest_pro_imem #(
        .OP_CODE_SIZE(4),
        .ROM_DEPTH(65536),
        .MEM_WORDS(MW),
        .READ_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .i_reset_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && (bus.o_instr_valid || bus.o_ERROR)) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: got valid=%0b err=%0b data=%h at cyc %0d, required none",
                         bus.o_instr_valid, bus.o_ERROR, bus.o_instruction, cyc);
            end else begin
                mx = sb.pop_front();
                if (bus.o_instr_valid !== mx.v || bus.o_ERROR !== mx.e ||
                    (mx.v && bus.o_instruction !== mx.d) || cyc != mx.due) begin
                    fails++;
                    $display("FAIL response: got valid=%0b err=%0b data=%h cyc=%0d, required valid=%0b err=%0b data=%h cyc=%0d",
                             bus.o_instr_valid, bus.o_ERROR, bus.o_instruction, cyc,
                             mx.v, mx.e, mx.d, mx.due);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic idle();
        bus.i_req          = 1'b0;
        bus.i_CS           = 1'b0;
        bus.i_WE           = 1'b0;
        bus.i_RESET        = 1'b0;
        bus.i_prog_counter = '0;
        bus.i_data2store   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int a, logic [W-1:0] d);
        bus.i_req          = 1'b1;
        bus.i_CS           = 1'b1;
        bus.i_WE           = 1'b1;
        bus.i_prog_counter = AW'(a);
        bus.i_data2store   = d;
        if (a >= MW) sb.push_back('{d: '0, v: 1'b0, e: 1'b1, due: cyc + 1 + LAT});
        step();
        idle();
    endtask

    task automatic rd(int a, logic [W-1:0] d);
        bus.i_req          = 1'b1;
        bus.i_CS           = 1'b1;
        bus.i_WE           = 1'b0;
        bus.i_prog_counter = AW'(a);
        sb.push_back('{d: d, v: 1'b1, e: (a >= MW), due: cyc + 1 + LAT});
        step();
        idle();
    endtask

    task automatic busy_req(bit cs);
        bus.i_req          = 1'b1;
        bus.i_CS           = cs;
        bus.i_WE           = 1'b0;
        bus.i_prog_counter = AW'(5);
        if (cs) sb.push_back('{d: '0, v: 1'b0, e: 1'b1, due: cyc + 1});
        step();
        idle();
    endtask

    task automatic soft_rst();
        bus.i_RESET = 1'b1;
        step();
        idle();
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!bus.o_busy) break;
            cnt++;
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_instr", 32'(bus.o_instruction), 32'h0);
        chk("rst_valid", 32'(bus.o_instr_valid), 32'h0);
        chk("rst_error", 32'(bus.o_ERROR), 32'h0);
        chk("rst_busy", 32'(bus.o_busy), 32'h1);
        mon_en = 1'b1;
        step();
        rst_n = 1'b1;
        count_busy(n);
        chk("busy_after_reset", n, 256);

        rd(5, 28'h0);
        wr(10, 28'h1234567);
        rd(10, 28'h1234567);
        wr(1, 28'hA);
        wr(2, 28'hB);
        wr(3, 28'hC);
        rd(1, 28'hA);
        rd(2, 28'hB);
        rd(3, 28'hC);
        wr(44, 28'h55);
        rd(300, 28'h0);
        wr(300, 28'hFFFFFFF);
        rd(44, 28'h55);
        rd(10, 28'h1234567);
        wr(20, 28'hBEEF01);
        rd(20, 28'hBEEF01);
        wr(255, 28'h7654321);
        rd(255, 28'h7654321);
        rd(256, 28'h0);

        bus.i_req          = 1'b1;
        bus.i_CS           = 1'b0;
        bus.i_WE           = 1'b1;
        bus.i_prog_counter = AW'(10);
        bus.i_data2store   = 28'hBAD0BAD;
        step();
        idle();
        rd(10, 28'h1234567);
        repeat (4) step();

        bus.i_req          = 1'b1;
        bus.i_CS           = 1'b1;
        bus.i_WE           = 1'b0;
        bus.i_prog_counter = AW'(10);
        step();
        idle();
        soft_rst();
        count_busy(n);
        chk("busy_after_soft_reset", n, 256);
        rd(10, 28'h0);
        rd(255, 28'h0);
        repeat (4) step();

        soft_rst();
        step();
        busy_req(1'b1);
        busy_req(1'b1);
        busy_req(1'b0);
        count_busy(n);
        chk("busy_remaining", n, 252);
        rd(5, 28'h0);

        repeat (6) step();
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
